// File: rtl/l2_interleave_xbar.sv
// L2 SRAM front-end: decodes per-port word requests onto NumBank banks (interleaved or linear
// window), round-robin arbitrates each bank, and returns in-order responses after RdLatency cycles.
module l2_interleave_xbar #(
    parameter int unsigned          NumPort       = 2,
    parameter int unsigned          NumBank       = 4,
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 64,
    parameter int unsigned          BankWords     = 256,
    parameter logic [AddrWidth-1:0] InterlBase    = AddrWidth'(48'h7800_0000),
    parameter logic [AddrWidth-1:0] NonInterlBase = AddrWidth'(48'h7840_0000),
    parameter int unsigned          RdLatency     = 1
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic [NumPort-1:0]                               port_req_i,
    output logic [NumPort-1:0]                               port_gnt_o,
    input  logic [NumPort-1:0][AddrWidth-1:0]                port_addr_i,
    input  logic [NumPort-1:0]                               port_we_i,
    input  logic [NumPort-1:0][DataWidth/8-1:0]              port_be_i,
    input  logic [NumPort-1:0][DataWidth-1:0]                port_wdata_i,
    output logic [NumPort-1:0]                               port_rvalid_o,
    output logic [NumPort-1:0][DataWidth-1:0]                port_rdata_o,
    output logic [NumPort-1:0]                               port_err_o,
    output logic [NumBank-1:0]                               bank_req_o,
    output logic [NumBank-1:0]                               bank_we_o,
    output logic [NumBank-1:0][$clog2(BankWords)-1:0]        bank_addr_o,
    output logic [NumBank-1:0][DataWidth/8-1:0]              bank_be_o,
    output logic [NumBank-1:0][DataWidth-1:0]                bank_wdata_o,
    input  logic [NumBank-1:0][DataWidth-1:0]                bank_rdata_i,
    input  logic                                             stat_clear_i,
    output logic [NumPort-1:0][15:0]                         conflict_cnt_o
);

    localparam int unsigned NB      = DataWidth / 8;
    localparam int unsigned BAW     = $clog2(BankWords);
    localparam int unsigned BW      = $clog2(NumBank);
    localparam int unsigned OffBits = $clog2(NB);
    localparam int unsigned PW      = (NumPort > 1) ? $clog2(NumPort) : 1;
    localparam logic [AddrWidth-1:0] MemSize = AddrWidth'(NumBank * BankWords * NB);

    logic [NumPort-1:0]                 dec_err;
    logic [NumPort-1:0][BW-1:0]         dec_bank;
    logic [NumPort-1:0][BAW-1:0]        dec_row;
    logic [NumBank-1:0]                 bank_hit;
    logic [NumBank-1:0][PW-1:0]         bank_win;
    logic [NumBank-1:0][PW-1:0]         ptr_d, ptr_q;
    logic [NumPort-1:0]                 gnt;
    logic [NumPort-1:0][15:0]           cnt_d, cnt_q;
    logic [NumPort-1:0][RdLatency-1:0]  pv_q, pe_q, pw_q;
    logic [NumPort-1:0][RdLatency-1:0][BW-1:0] pb_q;

    // Interleaved window is tested first so it wins if the two windows ever overlap.
    always_comb begin
        logic [AddrWidth-1:0] off_i, off_l, word_i, word_l;
        dec_err  = '0;
        dec_bank = '0;
        dec_row  = '0;
        for (int unsigned p = 0; p < NumPort; p++) begin
            off_i  = port_addr_i[p] - InterlBase;
            off_l  = port_addr_i[p] - NonInterlBase;
            word_i = off_i >> OffBits;
            word_l = off_l >> OffBits;
            if (port_addr_i[p] >= InterlBase && off_i < MemSize) begin
                dec_bank[p] = word_i[BW-1:0];
                dec_row[p]  = word_i[BW+BAW-1:BW];
            end else if (port_addr_i[p] >= NonInterlBase && off_l < MemSize) begin
                dec_bank[p] = word_l[BW+BAW-1:BAW];
                dec_row[p]  = word_l[BAW-1:0];
            end else begin
                dec_err[p] = 1'b1;
            end
        end
    end

    // Per-bank round-robin: scan ports starting at the pointer, first valid hit wins.
    always_comb begin
        int unsigned   idx;
        logic [PW-1:0] sel;
        bank_hit = '0;
        bank_win = '0;
        ptr_d    = ptr_q;
        idx      = 0;
        sel      = '0;
        for (int unsigned b = 0; b < NumBank; b++) begin
            for (int unsigned i = 0; i < NumPort; i++) begin
                idx = 32'(ptr_q[b]) + i;
                if (idx >= NumPort) begin
                    idx = idx - NumPort;
                end
                sel = PW'(idx);
                if (!bank_hit[b] && port_req_i[sel] && !dec_err[sel] &&
                    dec_bank[sel] == BW'(b)) begin
                    bank_hit[b] = 1'b1;
                    bank_win[b] = sel;
                end
            end
        end
        if (rst_i) begin
            bank_hit = '0;
        end
        for (int unsigned b = 0; b < NumBank; b++) begin
            if (bank_hit[b]) begin
                ptr_d[b] = (32'(bank_win[b]) == NumPort - 1) ? '0 : bank_win[b] + PW'(1);
            end
        end
    end

    // Decode errors are accepted at once without touching any bank.
    always_comb begin
        gnt = port_req_i & dec_err;
        for (int unsigned b = 0; b < NumBank; b++) begin
            if (bank_hit[b]) begin
                gnt[bank_win[b]] = 1'b1;
            end
        end
        if (rst_i) begin
            gnt = '0;
        end
    end

    assign port_gnt_o = gnt;

    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        for (int unsigned b = 0; b < NumBank; b++) begin
            if (bank_hit[b]) begin
                bank_req_o[b]   = 1'b1;
                bank_we_o[b]    = port_we_i[bank_win[b]];
                bank_addr_o[b]  = dec_row[bank_win[b]];
                bank_be_o[b]    = port_be_i[bank_win[b]];
                bank_wdata_o[b] = port_wdata_i[bank_win[b]];
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NumPort; p++) begin
            cnt_d[p] = cnt_q[p];
            if (stat_clear_i) begin
                cnt_d[p] = '0;
            end else if (port_req_i[p] && !gnt[p] && cnt_q[p] != 16'hFFFF) begin
                cnt_d[p] = cnt_q[p] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            pv_q  <= '0;
            pe_q  <= '0;
            pw_q  <= '0;
            pb_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            for (int unsigned p = 0; p < NumPort; p++) begin
                pv_q[p][0] <= gnt[p];
                pe_q[p][0] <= dec_err[p];
                pw_q[p][0] <= port_we_i[p];
                pb_q[p][0] <= dec_bank[p];
                for (int unsigned k = 1; k < RdLatency; k++) begin
                    pv_q[p][k] <= pv_q[p][k-1];
                    pe_q[p][k] <= pe_q[p][k-1];
                    pw_q[p][k] <= pw_q[p][k-1];
                    pb_q[p][k] <= pb_q[p][k-1];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NumPort; p++) begin
            port_rvalid_o[p] = pv_q[p][RdLatency-1];
            port_err_o[p]    = pv_q[p][RdLatency-1] & pe_q[p][RdLatency-1];
            port_rdata_o[p]  = '0;
            if (pv_q[p][RdLatency-1] && !pe_q[p][RdLatency-1] && !pw_q[p][RdLatency-1]) begin
                port_rdata_o[p] = bank_rdata_i[pb_q[p][RdLatency-1]];
            end
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_l2_interleave_xbar.sv
// Directed bench: a 2-port/latency-1 instance for decode, arbitration and responses, and an
// 8-port/latency-3 instance for latency, counter saturation and mid-flight reset.
module tb_l2_interleave_xbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic             rst_a, rst_b, clr_a, clr_b;
    logic [3:0][63:0] brd;

    logic [1:0]       req_a, we_a, gnt_a, rv_a, err_a;
    logic [1:0][47:0] addr_a;
    logic [1:0][7:0]  be_a;
    logic [1:0][63:0] wd_a, rd_a;
    logic [1:0][15:0] cnt_a;
    logic [3:0]       breq_a, bwe_a;
    logic [3:0][7:0]  baddr_a, bbe_a;
    logic [3:0][63:0] bwd_a;

    logic [7:0]       req_b, we_b, gnt_b, rv_b, err_b;
    logic [7:0][47:0] addr_b;
    logic [7:0][7:0]  be_b;
    logic [7:0][63:0] wd_b, rd_b;
    logic [7:0][15:0] cnt_b;
    logic [3:0]       breq_b, bwe_b;
    logic [3:0][7:0]  baddr_b, bbe_b;
    logic [3:0][63:0] bwd_b;

    l2_interleave_xbar u_dut_a (
        .clk_i          (clk),
        .rst_i          (rst_a),
        .port_req_i     (req_a),
        .port_gnt_o     (gnt_a),
        .port_addr_i    (addr_a),
        .port_we_i      (we_a),
        .port_be_i      (be_a),
        .port_wdata_i   (wd_a),
        .port_rvalid_o  (rv_a),
        .port_rdata_o   (rd_a),
        .port_err_o     (err_a),
        .bank_req_o     (breq_a),
        .bank_we_o      (bwe_a),
        .bank_addr_o    (baddr_a),
        .bank_be_o      (bbe_a),
        .bank_wdata_o   (bwd_a),
        .bank_rdata_i   (brd),
        .stat_clear_i   (clr_a),
        .conflict_cnt_o (cnt_a)
    );

    l2_interleave_xbar #(
        .NumPort   (8),
        .RdLatency (3)
    ) u_dut_b (
        .clk_i          (clk),
        .rst_i          (rst_b),
        .port_req_i     (req_b),
        .port_gnt_o     (gnt_b),
        .port_addr_i    (addr_b),
        .port_we_i      (we_b),
        .port_be_i      (be_b),
        .port_wdata_i   (wd_b),
        .port_rvalid_o  (rv_b),
        .port_rdata_o   (rd_b),
        .port_err_o     (err_b),
        .bank_req_o     (breq_b),
        .bank_we_o      (bwe_b),
        .bank_addr_o    (baddr_b),
        .bank_be_o      (bbe_b),
        .bank_wdata_o   (bwd_b),
        .bank_rdata_i   (brd),
        .stat_clear_i   (clr_b),
        .conflict_cnt_o (cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        req_a = '0; we_a = '0; addr_a = '0; be_a = '0; wd_a = '0;
        req_b = '0; we_b = '0; addr_b = '0; be_b = '0; wd_b = '0;
        for (int b = 0; b < 4; b++) brd[b] = 64'h0DA7_A000_0000_00B0 | 64'(b);
        repeat (2) tick();

        // Requests are blocked while reset is high
        req_a = 2'b01; addr_a[0] = 48'h7800_0018;
        #1;
        chk("rst_gnt", 64'(gnt_a), 64'h0);
        chk("rst_breq", 64'(breq_a), 64'h0);
        chk("rst_cnt", 64'(cnt_a[0]), 64'h0);
        chk("rst_rvalid", 64'(rv_a), 64'h0);
        req_a = '0; rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Interleaved read: word 3 -> bank 3 row 0
        req_a = 2'b01; addr_a[0] = 48'h7800_0018; we_a = 2'b00;
        #1;
        chk("rd_gnt", 64'(gnt_a), 64'h1);
        chk("rd_breq", 64'(breq_a), 64'h8);
        chk("rd_row", 64'(baddr_a[3]), 64'h0);
        chk("rd_bwe", 64'(bwe_a), 64'h0);
        tick();
        req_a = '0;
        #1;
        chk("rd_rvalid", 64'(rv_a), 64'h1);
        chk("rd_rdata", rd_a[0], brd[3]);
        chk("rd_err", 64'(err_a), 64'h0);

        // Linear write: word 0x101 -> bank 1 row 1
        req_a = 2'b10; addr_a[1] = 48'h7840_0808; we_a = 2'b10; be_a[1] = 8'h0F;
        wd_a[1] = 64'h1122_3344_5566_7788;
        #1;
        chk("wr_gnt", 64'(gnt_a), 64'h2);
        chk("wr_breq", 64'(breq_a), 64'h2);
        chk("wr_row", 64'(baddr_a[1]), 64'h1);
        chk("wr_bwe", 64'(bwe_a), 64'h2);
        chk("wr_bbe", 64'(bbe_a[1]), 64'h0F);
        chk("wr_bwdata", bwd_a[1], 64'h1122_3344_5566_7788);
        tick();
        req_a = '0; we_a = '0;
        #1;
        chk("wr_rvalid", 64'(rv_a), 64'h2);
        chk("wr_rdata", rd_a[1], 64'h0);

        // Both ports hammer bank 0: grants alternate starting with port 0
        req_a = 2'b11; addr_a[0] = 48'h7800_0000; addr_a[1] = 48'h7800_0020;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_gnt", 64'(gnt_a), (c % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_row", 64'(baddr_a[0]), (c % 2 == 0) ? 64'h0 : 64'h1);
            if (c > 0) chk("rr_rvalid", 64'(rv_a), (c % 2 == 0) ? 64'h2 : 64'h1);
            tick();
        end
        req_a = '0;
        #1;
        chk("rr_last_rvalid", 64'(rv_a), 64'h2);
        chk("rr_last_rdata", rd_a[1], brd[0]);
        chk("rr_cnt0", 64'(cnt_a[0]), 64'd3);
        chk("rr_cnt1", 64'(cnt_a[1]), 64'd3);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        #1;
        chk("clr_cnt0", 64'(cnt_a[0]), 64'h0);
        chk("clr_cnt1", 64'(cnt_a[1]), 64'h0);

        // Window end is exclusive; last linear word maps to bank 3 row 255
        req_a = 2'b11; addr_a[0] = 48'h7800_2000; addr_a[1] = 48'h7840_1FF8;
        #1;
        chk("end_gnt", 64'(gnt_a), 64'h3);
        chk("end_breq", 64'(breq_a), 64'h8);
        chk("end_row", 64'(baddr_a[3]), 64'hFF);
        tick();
        req_a = '0;
        #1;
        chk("end_rvalid", 64'(rv_a), 64'h3);
        chk("end_err", 64'(err_a), 64'h1);
        chk("end_rdata0", rd_a[0], 64'h0);
        chk("end_rdata1", rd_a[1], brd[3]);

        // Below-base address errors; last interleaved word -> bank 3 row 255
        req_a = 2'b11; addr_a[0] = 48'h77FF_FFF8; addr_a[1] = 48'h7800_1FF8;
        #1;
        chk("low_gnt", 64'(gnt_a), 64'h3);
        chk("low_breq", 64'(breq_a), 64'h8);
        chk("low_row", 64'(baddr_a[3]), 64'hFF);
        tick();
        // Different banks are served in parallel
        req_a = 2'b11; addr_a[0] = 48'h7800_0008; addr_a[1] = 48'h7800_0010;
        #1;
        chk("low_err", 64'(err_a), 64'h1);
        chk("par_gnt", 64'(gnt_a), 64'h3);
        chk("par_breq", 64'(breq_a), 64'h6);
        tick();
        req_a = '0;

        // Latency 3: response appears on the third cycle after grant
        req_b = 8'h20; addr_b[5] = 48'h7800_0010;
        #1;
        chk("lat_gnt", 64'(gnt_b), 64'h20);
        tick();
        req_b = '0;
        #1;
        chk("lat_rv1", 64'(rv_b), 64'h0);
        tick();
        chk("lat_rv2", 64'(rv_b), 64'h0);
        tick();
        chk("lat_rv3", 64'(rv_b), 64'h20);
        chk("lat_rdata", rd_b[5], brd[2]);

        // Eight ports on bank 0: each stalls 7 of every 8 cycles, then saturates
        for (int p = 0; p < 8; p++) addr_b[p] = 48'h7800_0000;
        req_b = 8'hFF;
        repeat (8) tick();
        chk("sat_cnt0_8", 64'(cnt_b[0]), 64'd7);
        chk("sat_cnt1_8", 64'(cnt_b[1]), 64'd7);
        chk("sat_cnt7_8", 64'(cnt_b[7]), 64'd7);
        chk("sat_gnt_wrap", 64'(gnt_b), 64'h01);
        repeat (76000) tick();
        chk("sat_cnt1", 64'(cnt_b[1]), 64'hFFFF);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0; req_b = '0;
        #1;
        chk("sat_clr1", 64'(cnt_b[1]), 64'h0);
        chk("sat_clr0", 64'(cnt_b[0]), 64'h0);
        repeat (4) tick();

        // Grant, then reset one cycle later drops the in-flight response
        addr_b[2] = 48'h7800_0008; addr_b[3] = 48'h7800_0008; req_b = 8'h0C;
        #1;
        chk("fl_gnt", 64'(gnt_b), 64'h04);
        tick();
        rst_b = 1'b1; req_b = 8'h08;
        #1;
        chk("fl_rst_gnt", 64'(gnt_b), 64'h0);
        chk("fl_rst_breq", 64'(breq_b), 64'h0);
        chk("fl_cnt_pre", 64'(cnt_b[3]), 64'd1);
        tick();
        rst_b = 1'b0; req_b = '0;
        #1;
        chk("fl_cnt_post", 64'(cnt_b[3]), 64'h0);
        chk("fl_rv0", 64'(rv_b), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fl_rv", 64'(rv_b), 64'h0);
        end
        for (int p = 0; p < 8; p++) addr_b[p] = 48'h7800_0008;
        req_b = 8'hFF;
        #1;
        chk("ptr_rst_gnt0", 64'(gnt_b), 64'h01);
        tick();
        chk("ptr_rst_gnt1", 64'(gnt_b), 64'h02);
        req_b = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
